sec_tick_gen: RTL and testbench

Upstream timebase for the countdown display digit. Divides `clk` down to a one-cycle `one_sec_flag` pulse at `TICK_HZ`, which drives the countdown counter's decrement. A user pushbutton toggles between running and paused. The button path is synchronized and optionally debounced. While paused, no ticks are issued and prescaler progress is preserved.

---
 rtl/sec_tick_gen.sv | 166 ++++++++++++++++
 tb/tb_sec_tick_gen.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: divides clk down to a one-cycle one_sec_flag pulse every
// CLK_HZ/TICK_HZ cycles, with a pushbutton that toggles run/pause.
//
// Ports:
//   clk          in   system clock
//   n_rst        in   synchronous active-low reset
//   btn_n        in   raw active-low pushbutton (async, may bounce)
//   run_out      out  1 = RUNNING, 0 = PAUSED
//   one_sec_flag out  registered single-cycle tick pulse
//
// Build option: define SEC_TICK_DEBOUNCE_EN to add the DEBOUNCE_CYCLES
// stability window on the button; otherwise the synchronized button
// goes through a single flop.

module sec_tick_gen #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn_n,
  output logic run_out,
  output logic one_sec_flag
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DIV - 1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t state;
  state_t state_n;

  logic sync_q1;
  logic sync;
  logic deb;
  logic deb_prev;
  logic press;

  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; idles high
  // like the released button.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q1 <= 1'b1;
      sync    <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync    <= sync_q1;
    end
  end

`ifdef SEC_TICK_DEBOUNCE_EN
  localparam int DB_W =
    $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;

  // Any cycle where sync agrees with deb
  // restarts the window, so a bounce back
  // to the old level throws away progress.
  // The D-th disagreeing cycle commits.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      db_cnt <= '0;
      deb    <= 1'b1;
    end else if (sync == deb) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      deb    <= sync;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      deb <= 1'b1;
    end else begin
      deb <= sync;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      deb_prev <= 1'b1;
    end else begin
      deb_prev <= deb;
    end
  end

  // Only the press (falling) edge acts;
  // release is ignored.
  assign press = deb_prev & ~deb;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= RUNNING;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUNNING: begin
        if (press) begin
          state_n = PAUSED;
        end
      end
      PAUSED: begin
        if (press) begin
          state_n = RUNNING;
        end
      end
      default: begin
        state_n = RUNNING;
      end
    endcase
  end

  assign run_out = (state == RUNNING);

  // Prescaler follows the state *before*
  // any press this cycle: a pause press on
  // the last count still ticks, and a
  // resume press on a held last count
  // ticks one cycle later.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt          <= '0;
      one_sec_flag <= 1'b0;
    end else if (state == RUNNING) begin
      if (cnt == CNT_LAST) begin
        cnt          <= '0;
        one_sec_flag <= 1'b1;
      end else begin
        cnt          <= cnt + 1'b1;
        one_sec_flag <= 1'b0;
      end
    end else begin
      one_sec_flag <= 1'b0;
    end
  end

  // Parameter sanity; ignored by synthesis.
  always_ff @(posedge clk) begin
    cfg_chk: assert (DIV >= 2 &&
                     DEBOUNCE_CYCLES >= 1);
  end

endmodule

// File: tb/tb_sec_tick_gen.sv
// tb_sec_tick_gen: directed table, corner sequences and random button
// traffic checked against a cycle-count reference model.

module tb_sec_tick_gen;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int D       = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef SEC_TICK_DEBOUNCE_EN
  localparam int DW = D;
`else
  localparam int DW = 1;
`endif
  localparam int LAT = DW + 2;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic btn_n = 1'b1;
  logic run_out;
  logic one_sec_flag;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  sec_tick_gen #(
    .CLK_HZ         (CLK_HZ),
    .TICK_HZ        (TICK_HZ),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .btn_n       (btn_n),
    .run_out     (run_out),
    .one_sec_flag(one_sec_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: deb flips once the last
  // DW synchronized samples all disagree with
  // it; a tick is every DIV-th running cycle.
  bit m_s1   = 1'b1;
  bit m_s2   = 1'b1;
  bit m_deb  = 1'b1;
  bit m_prev = 1'b1;
  bit m_run  = 1'b1;
  bit m_flag = 1'b0;
  int m_rc   = 0;
  bit hist[$];

  always @(posedge clk) begin
    bit osync;
    bit flip;
    bit prs;
    bit tick;
    if (!n_rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_deb = 1'b1; m_prev = 1'b1;
      m_run = 1'b1; m_flag = 1'b0;
      m_rc = 0;
      hist.delete();
    end else begin
      osync = m_s2;
      hist.push_back(osync);
      if (hist.size() > DW)
        void'(hist.pop_front());
      flip = (hist.size() == DW);
      foreach (hist[i])
        if (hist[i] == m_deb) flip = 1'b0;
      prs  = m_prev && !m_deb;
      tick = m_run && ((m_rc + 1) % DIV == 0);
      if (m_run) m_rc++;
      m_flag = tick;
      if (prs) m_run = !m_run;
      m_prev = m_deb;
      if (flip) m_deb = osync;
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mdl_run", run_out, m_run);
      chk("mdl_flag", one_sec_flag, m_flag);
    end
  end

  // Drive one input value, return after the
  // edge that sampled it has settled.
  task automatic cyc(input logic b);
    btn_n = b;
    @(negedge clk);
  endtask

  // Hold the button so the toggle lands on an
  // edge where the pre-edge count is target
  // (when running); report flag/run after it.
  task automatic press_at(input int target,
                          input bit paused,
                          output logic f_at,
                          output logic r_at);
    int guard;
    guard = 0;
    repeat (DW + 2) cyc(1'b1);
    if (!paused) begin
      while ((((m_rc % DIV) + LAT) % DIV
              != target) && guard < 4 * DIV) begin
        cyc(1'b1);
        guard++;
      end
    end
    for (int k = 0; k <= LAT; k++) cyc(1'b0);
    f_at = one_sec_flag;
    r_at = run_out;
  endtask

  typedef struct {
    logic btn;
    logic exp_run;
    logic chk_flag;
    logic exp_flag;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic f;
    logic r;
    logic r0;
    int   n;
    int   bp[4];

    for (int c = 1; c <= 35; c++)
      tbl.push_back('{1'b1, 1'b1, 1'b1,
                      logic'(c % DIV == 0)});
    for (int k = 0; k < 20; k++)
      tbl.push_back('{1'b0, logic'(k < LAT),
                      1'b0, 1'b0});
    for (int k = 0; k < 15; k++)
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 20; k++)
      tbl.push_back('{1'b0, logic'(k >= LAT),
                      1'b0, 1'b0});
    for (int k = 0; k < 15; k++)
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0});

    n_rst = 1'b0;
    btn_n = 1'b1;
    @(negedge clk);
    cyc(1'b1);
    cyc(1'b1);
    chk("rst_run", run_out, 1'b1);
    chk("rst_flag", one_sec_flag, 1'b0);
    mon_en = 1'b1;

    n_rst = 1'b1;
    foreach (tbl[i]) begin
      cyc(tbl[i].btn);
      chk($sformatf("tbl%0d_run", i),
          run_out, tbl[i].exp_run);
      if (tbl[i].chk_flag)
        chk($sformatf("tbl%0d_flag", i),
            one_sec_flag, tbl[i].exp_flag);
    end

    // reset mid-count restarts the prescaler
    repeat (3) cyc(1'b1);
    n_rst = 1'b0;
    cyc(1'b1);
    chk("midrst_flag", one_sec_flag, 1'b0);
    chk("midrst_run", run_out, 1'b1);
    n_rst = 1'b1;
    for (int c = 1; c <= DIV; c++) begin
      cyc(1'b1);
      chk($sformatf("postrst%0d", c),
          one_sec_flag, logic'(c == DIV));
    end

    // bounce: low 3, high 1, low 3, high 10
    bp = '{3, 1, 3, 10};
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < bp[s]; k++) begin
        cyc(logic'(s % 2));
`ifdef SEC_TICK_DEBOUNCE_EN
        chk("bounce_run", run_out, 1'b1);
`endif
      end
    end

    // single-cycle glitch
    r0 = run_out;
    cyc(1'b0);
    repeat (3) cyc(1'b1);
`ifdef SEC_TICK_DEBOUNCE_EN
    chk("glitch_run", run_out, r0);
`else
    chk("glitch_run", run_out, ~r0);
`endif
    if (run_out !== 1'b1) begin
      press_at(0, 1'b1, f, r);
      chk("glitch_restore", r, 1'b1);
    end

    // pause with held count 6
    press_at(5, 1'b0, f, r);
    chk("pause_run", r, 1'b0);
    n = 0;
    repeat (50) begin
      cyc(1'b1);
      if (one_sec_flag) n++;
    end
    chk_int("pause_pulses", n, 0);
    press_at(0, 1'b1, f, r);
    chk("resume_run", r, 1'b1);
    chk("resume_flag", f, 1'b0);
    for (n = 1; n <= 20; n++) begin
      cyc(1'b1);
      if (one_sec_flag) break;
    end
    chk_int("resume_gap", n, 4);

    // pause press on the last count still ticks
    press_at(DIV - 1, 1'b0, f, r);
    chk("sim_run_flag", f, 1'b1);
    chk("sim_run_run", r, 1'b0);
    press_at(0, 1'b1, f, r);
    chk("sim_resume", r, 1'b1);

    // resume press on a held last count
    press_at(DIV - 2, 1'b0, f, r);
    chk("sim_hold_run", r, 1'b0);
    chk("sim_hold_flag", f, 1'b0);
    press_at(0, 1'b1, f, r);
    chk("sim_pause_flag", f, 1'b0);
    chk("sim_pause_run", r, 1'b1);
    cyc(1'b1);
    chk("sim_pause_next", one_sec_flag, 1'b1);

    // random button traffic and resets
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        n_rst = 1'b0;
        cyc(1'b1);
        n_rst = 1'b1;
      end
      r0 = logic'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 12));
      repeat (n) cyc(r0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
